hd_pair_sched: RTL and testbench

- Sequenced, time-shared version of the Hamming(7,4) pair decoder/adder. It accepts one pair of 7-bit code words per valid/ready transaction.
- A single shared decoder unit is scheduled over two cycles: word1 first, then word2. The block then forms the signed combined result.
- Results are presented on a valid/ready output port with backpressure.
- It keeps a running accumulator and a saturating pair counter for the downstream stage.

---
 rtl/hd_pair_sched_if.sv | 22 ++
 rtl/hd_pair_sched.sv | 144 ++++++++++++++
 tb/tb_hd_pair_sched.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/hd_pair_sched_if.sv
// rtl/hd_pair_sched_if.sv - code-word pair input and result output handshake bundle
interface hd_pair_sched_if;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] code_word1;
  logic [6:0] code_word2;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_n;

  // Producer of pairs and consumer of results
  modport master (
    output in_valid, code_word1, code_word2, out_ready,
    input  in_ready, out_valid, out_n
  );

  // The scheduler itself
  modport slave (
    input  in_valid, code_word1, code_word2, out_ready,
    output in_ready, out_valid, out_n
  );
endinterface

// File: rtl/hd_pair_sched.sv
// rtl/hd_pair_sched.sv - time-shared Hamming(7,4) pair decoder/adder with accumulator
module hd_pair_sched #(
  parameter int ACC_W = 10,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  hd_pair_sched_if.slave       bus,
  input  logic                 acc_clr,
  output logic [ACC_W-1:0]     acc_sum,
  output logic [CNT_W-1:0]     pair_cnt
);

  typedef enum logic [1:0] {IDLE, DEC1, DEC2, OUT} state_t;

  state_t             state_q, state_d;
  logic [6:0]         w1_q, w1_d, w2_q, w2_d;
  logic [3:0]         c1_q, c1_d;
  logic               opt1_q, opt1_d;
  logic [5:0]         out_n_q, out_n_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [6:0]         dec_in;
  logic [2:0]         syn;
  logic [6:0]         err;
  logic               dec_opt;
  logic [3:0]         dec_c;
  logic [5:0]         a6, b6, res;
  logic               hs;

  // Single shared decoder: word1 during DEC1, word2 during DEC2
  always_comb begin
    dec_in = (state_q == DEC2) ? w2_q : w1_q;
    syn = {dec_in[6] ^ dec_in[3] ^ dec_in[2] ^ dec_in[1],
           dec_in[5] ^ dec_in[3] ^ dec_in[2] ^ dec_in[0],
           dec_in[4] ^ dec_in[3] ^ dec_in[1] ^ dec_in[0]};
    case (syn)
      3'b001:  err = 7'b001_0000;
      3'b010:  err = 7'b010_0000;
      3'b100:  err = 7'b100_0000;
      3'b011:  err = 7'b000_0001;
      3'b101:  err = 7'b000_0010;
      3'b110:  err = 7'b000_0100;
      default: err = 7'b000_1000;  // 111, and 000 which cannot occur with one flip
    endcase
    dec_opt = |(dec_in & err);
    dec_c   = dec_in[3:0] ^ err[3:0];
  end

  // Combine first (registered) and second (live) decode into the 6-bit signed result
  always_comb begin
    a6 = {{2{c1_q[3]}}, c1_q};
    b6 = {{2{dec_c[3]}}, dec_c};
    case ({opt1_q, dec_opt})
      2'b00:   res = a6 + a6 + b6;
      2'b01:   res = a6 + a6 - b6;
      2'b10:   res = a6 - b6 - b6;
      default: res = a6 + b6 + b6;
    endcase
  end

  // Next-state, datapath capture, accumulator and saturating counter
  always_comb begin
    state_d     = state_q;
    w1_d        = w1_q;
    w2_d        = w2_q;
    c1_d        = c1_q;
    opt1_d      = opt1_q;
    out_n_d     = out_n_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    hs          = out_valid_q & bus.out_ready;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          w1_d       = bus.code_word1;
          w2_d       = bus.code_word2;
          in_ready_d = 1'b0;
          state_d    = DEC1;
        end
      end
      DEC1: begin
        c1_d    = dec_c;
        opt1_d  = dec_opt;
        state_d = DEC2;
      end
      DEC2: begin
        out_n_d     = res;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      default: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
    endcase

    // Clear takes priority over the old sum but not over the current handshake
    acc_d = (acc_clr ? '0 : acc_q) +
            (hs ? {{(ACC_W-6){out_n_q[5]}}, out_n_q} : '0);
    cnt_d = (hs && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
  end

  // All state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      w1_q        <= '0;
      w2_q        <= '0;
      c1_q        <= '0;
      opt1_q      <= 1'b0;
      out_n_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      w1_q        <= w1_d;
      w2_q        <= w2_d;
      c1_q        <= c1_d;
      opt1_q      <= opt1_d;
      out_n_q     <= out_n_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_n     = out_n_q;
  assign acc_sum       = acc_q;
  assign pair_cnt      = cnt_q;

endmodule

// File: tb/tb_hd_pair_sched.sv
// tb/tb_hd_pair_sched.sv - scoreboard bench for hd_pair_sched
module tb_hd_pair_sched;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       acc_clr = 1'b0;
  logic [9:0] acc_sum;
  logic [7:0] pair_cnt;

  hd_pair_sched_if bus();

  hd_pair_sched #(.ACC_W(10), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .acc_clr(acc_clr), .acc_sum(acc_sum), .pair_cnt(pair_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  logic [5:0] exp_q[$];
  logic [9:0] m_acc = '0;
  logic [7:0] m_cnt = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Encoder: valid Hamming(7,4) word from data, then flip bit p
  function automatic logic [6:0] enc(input logic [3:0] d, input int p);
    logic [6:0] cw;
    cw = {d[3] ^ d[2] ^ d[1], d[3] ^ d[2] ^ d[0], d[3] ^ d[1] ^ d[0], d};
    cw[p] = ~cw[p];
    return cw;
  endfunction

  function automatic logic [5:0] model(input logic [3:0] c1, input logic o1,
                                       input logic [3:0] c2, input logic o2);
    int a, b, r;
    a = $signed(c1);
    b = $signed(c2);
    case ({o1, o2})
      2'b00:   r = 2 * a + b;
      2'b01:   r = 2 * a - b;
      2'b10:   r = a - 2 * b;
      default: r = a + 2 * b;
    endcase
    return r[5:0];
  endfunction

  task automatic gen_pair(output logic [6:0] cw1, output logic [6:0] cw2, output logic [5:0] e);
    logic [3:0] d1, d2;
    int p1, p2;
    d1 = 4'($urandom_range(0, 15));
    d2 = 4'($urandom_range(0, 15));
    p1 = $urandom_range(0, 6);
    p2 = $urandom_range(0, 6);
    cw1 = enc(d1, p1);
    cw2 = enc(d2, p2);
    e = model(d1, cw1[p1], d2, cw2[p2]);
  endtask

  // Present a pair, wait (bounded) for in_ready, return just after the accepting edge
  task automatic send(input logic [6:0] cw1, input logic [6:0] cw2, input logic [5:0] e);
    int t = 0;
    bus.code_word1 = cw1;
    bus.code_word2 = cw2;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 50) begin
      tick();
      t++;
    end
    check("in_ready_seen", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    exp_q.push_back(e);
  endtask

  // Take one result (optionally with acc_clr on the handshake edge) and check it
  task automatic recv(input logic clr);
    int t = 0;
    logic [5:0] e;
    bus.out_ready = 1'b1;
    while (!bus.out_valid && t < 50) begin
      tick();
      t++;
    end
    check("out_valid_seen", bus.out_valid, 1);
    check("sb_nonempty", exp_q.size() != 0, 1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 6'h0;
    check("out_n", bus.out_n, e);
    acc_clr = clr;
    tick();
    acc_clr = 1'b0;
    bus.out_ready = 1'b0;
    m_acc = (clr ? 10'h0 : m_acc) + {{4{e[5]}}, e};
    if (m_cnt != 8'hFF) m_cnt++;
    check("acc_sum", acc_sum, m_acc);
    check("pair_cnt", pair_cnt, m_cnt);
  endtask

  initial begin
    logic [6:0] a, b;
    logic [5:0] e;

    bus.in_valid = 1'b0;
    bus.code_word1 = '0;
    bus.code_word2 = '0;
    bus.out_ready = 1'b0;

    tick();
    tick();
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_n", bus.out_n, 0);
    check("rst_acc", acc_sum, 0);
    check("rst_cnt", pair_cnt, 0);
    rst_n = 1'b1;
    tick();

    // Basic pair with latency: out_valid must rise exactly at T+3
    bus.out_ready = 1'b1;
    send(7'b0100011, 7'b1000110, 6'b000100);
    check("lat_t1_valid", bus.out_valid, 0);
    check("lat_t1_ready", bus.in_ready, 0);
    tick();
    check("lat_t2_valid", bus.out_valid, 0);
    tick();
    check("lat_t3_valid", bus.out_valid, 1);
    recv(1'b0);

    // Opt 11 pair, accumulator goes 4 + (-1) = 3
    send(7'b1110011, 7'b1001111, 6'b111111);
    recv(1'b0);
    check("acc_is_3", acc_sum, 10'd3);

    // Clear coinciding with a +4 handshake, then clear alone
    send(7'b0100011, 7'b1000110, 6'b000100);
    recv(1'b1);
    check("clr_add_4", acc_sum, 10'd4);
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    m_acc = '0;
    check("clr_alone", acc_sum, 10'd0);
    check("clr_cnt_kept", pair_cnt, 8'd3);

    // Extreme: c1=-8 opt1=1, c2=7 opt2=0 -> -22
    send(enc(4'b1000, 0), enc(4'b0111, 1), 6'b101010);
    recv(1'b0);
    check("acc_neg22", acc_sum, 10'h3EA);

    // Backpressure with a second pair waiting on the input
    gen_pair(a, b, e);
    send(a, b, e);
    bus.out_ready = 1'b0;
    gen_pair(a, b, e);
    bus.code_word1 = a;
    bus.code_word2 = b;
    bus.in_valid = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", bus.out_valid, 1);
      check("bp_out_n", bus.out_n, exp_q[0]);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_acc", acc_sum, m_acc);
      check("bp_cnt", pair_cnt, m_cnt);
    end
    recv(1'b0);
    check("bp_ready_after", bus.in_ready, 1);
    send(a, b, e);
    recv(1'b0);

    // Random stream long enough to drive pair_cnt into saturation and wrap acc
    for (int i = 0; i < 252; i++) begin
      gen_pair(a, b, e);
      send(a, b, e);
      recv(1'b0);
    end
    check("cnt_saturated", pair_cnt, 8'hFF);

    // Reset during DEC2 discards the pair
    gen_pair(a, b, e);
    send(a, b, e);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    m_acc = '0;
    m_cnt = '0;
    check("mid_rst_in_ready", bus.in_ready, 1);
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_out_n", bus.out_n, 0);
    check("mid_rst_acc", acc_sum, 0);
    check("mid_rst_cnt", pair_cnt, 0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("no_stale", bus.out_valid, 0);
    end
    bus.out_ready = 1'b0;
    gen_pair(a, b, e);
    send(a, b, e);
    recv(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
